// File: rtl/product_bcd_display_if.sv
// -----------------------------------------------------------------------------
// product_bcd_display_if
//
// Groups the multiplier-facing signals of product_bcd_display.
//
//   product_in  [15:0]  unsigned 8x8 product presented by the multiplier
//   done_flag           multiplier completion flag; a rising edge requests capture
//   busy                high while a binary-to-BCD conversion is running
//   bcd_valid           one-clock pulse marking a freshly loaded bcd_out
//   bcd_out     [19:0]  five packed BCD digits, [3:0] = units
//
// master : the producer side (multiplier / testbench)
// slave  : the conversion block
// -----------------------------------------------------------------------------
interface product_bcd_display_if;
    logic [15:0] product_in;
    logic        done_flag;
    logic        busy;
    logic        bcd_valid;
    logic [19:0] bcd_out;

    modport master (
        output product_in,
        output done_flag,
        input  busy,
        input  bcd_valid,
        input  bcd_out
    );

    modport slave (
        input  product_in,
        input  done_flag,
        output busy,
        output bcd_valid,
        output bcd_out
    );
endinterface

// File: rtl/product_bcd_display.sv
// -----------------------------------------------------------------------------
// product_bcd_display
//
// Captures a 16-bit unsigned product on a rising edge of done_flag, converts it
// to five BCD digits with a sequential double-dabble (one shift per clock,
// 16 shifts), publishes the result on bcd_out with a one-clock bcd_valid pulse,
// and continuously multiplexes the digits onto a 5-digit 7-segment display
// with leading-zero blanking.
//
// Parameters
//   REFRESH_DIV  clocks each digit stays enabled before the scan advances
//                (2..65535)
//
// Ports
//   clk          rising-edge clock
//   reset_a      asynchronous active-low reset
//   bus          product_bcd_display_if.slave: product_in, done_flag (in);
//                busy, bcd_valid, bcd_out (out)
//   digit_en     active-low one-hot digit enables, bit i = BCD digit i
//   seg_a..seg_g active-high segments of the currently enabled digit
// -----------------------------------------------------------------------------
module product_bcd_display #(
    parameter int unsigned REFRESH_DIV = 16
) (
    input  logic                        clk,
    input  logic                        reset_a,
    product_bcd_display_if.slave        bus,
    output logic [4:0]                  digit_en,
    output logic                        seg_a,
    output logic                        seg_b,
    output logic                        seg_c,
    output logic                        seg_d,
    output logic                        seg_e,
    output logic                        seg_f,
    output logic                        seg_g
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        UPDATE  = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // Double-dabble correction: any BCD nibble that will reach 10 or more after
    // the next shift is pre-biased by 3 so the shift carries into the next digit.
    function automatic logic [19:0] dd_adjust(input logic [19:0] w);
        logic [19:0] r;
        r = w;
        for (int i = 0; i < 5; i++) begin
            if (w[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = w[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Segment pattern {a,b,c,d,e,f,g}; non-decimal nibbles stay dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // -------------------------------------------------------------------------
    // Declarations
    // -------------------------------------------------------------------------
    state_t            state_q;
    state_t            state_d;

    logic              done_q;
    logic              done_rise;

    logic              capture;
    logic              shift_en;
    logic              finish;

    logic [3:0]        iter_q;
    logic [15:0]       operand_q;
    logic [19:0]       work_q;
    logic [35:0]       shifted;

    logic [19:0]       bcd_out_q;
    logic              bcd_valid_q;

    logic [CNT_W-1:0]  refresh_q;
    logic [2:0]        digit_idx_q;

    logic [3:0]        nibble;
    logic              blank;
    logic [6:0]        seg_bits;

    // -------------------------------------------------------------------------
    // Stage: done_flag edge detection
    // -------------------------------------------------------------------------
    // History resets to 0, so a done_flag already high at reset release is
    // seen as a rising edge on the first clock.
    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            done_q <= 1'b0;
        end else begin
            done_q <= bus.done_flag;
        end
    end

    assign done_rise = bus.done_flag & ~done_q;

    // -------------------------------------------------------------------------
    // Stage: control FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Edges are only looked at in IDLE, so anything arriving while busy is
    // dropped rather than queued.
    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        shift_en = 1'b0;
        finish   = 1'b0;
        case (state_q)
            IDLE: begin
                if (done_rise) begin
                    capture = 1'b1;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                shift_en = 1'b1;
                if (iter_q == 4'd15) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                finish  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy = (state_q != IDLE);

    // Shift count: cleared on capture, wraps back to 0 on the 16th shift.
    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            iter_q <= 4'd0;
        end else if (capture) begin
            iter_q <= 4'd0;
        end else if (shift_en) begin
            iter_q <= iter_q + 4'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Stage: double-dabble datapath
    // -------------------------------------------------------------------------
    assign shifted = {dd_adjust(work_q), operand_q} << 1;

    // Pure data: no reset. Anything left here after an aborted conversion is
    // overwritten by the next capture and never reaches bcd_out.
    always_ff @(posedge clk) begin
        if (capture) begin
            operand_q <= bus.product_in;
            work_q    <= 20'd0;
        end else if (shift_en) begin
            operand_q <= shifted[15:0];
            work_q    <= shifted[35:16];
        end
    end

    // -------------------------------------------------------------------------
    // Stage: result register
    // -------------------------------------------------------------------------
    // bcd_out only changes in UPDATE, so the display never sees partial work.
    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            bcd_out_q   <= 20'd0;
            bcd_valid_q <= 1'b0;
        end else begin
            bcd_valid_q <= finish;
            if (finish) begin
                bcd_out_q <= work_q;
            end
        end
    end

    assign bus.bcd_out   = bcd_out_q;
    assign bus.bcd_valid = bcd_valid_q;

    // -------------------------------------------------------------------------
    // Stage: display scan
    // -------------------------------------------------------------------------
    // Free-running, independent of the conversion FSM.
    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            refresh_q   <= '0;
            digit_idx_q <= 3'd0;
        end else if (refresh_q == CNT_LAST) begin
            refresh_q   <= '0;
            digit_idx_q <= (digit_idx_q == 3'd4) ? 3'd0 : digit_idx_q + 3'd1;
        end else begin
            refresh_q   <= refresh_q + 1'b1;
        end
    end

    // A digit is blanked when it and every more significant digit are zero;
    // digit 0 is always shown so a zero result reads "0".
    always_comb begin
        nibble = 4'd0;
        blank  = 1'b1;
        case (digit_idx_q)
            3'd0: begin
                nibble = bcd_out_q[3:0];
                blank  = 1'b0;
            end
            3'd1: begin
                nibble = bcd_out_q[7:4];
                blank  = (bcd_out_q[19:4] == '0);
            end
            3'd2: begin
                nibble = bcd_out_q[11:8];
                blank  = (bcd_out_q[19:8] == '0);
            end
            3'd3: begin
                nibble = bcd_out_q[15:12];
                blank  = (bcd_out_q[19:12] == '0);
            end
            3'd4: begin
                nibble = bcd_out_q[19:16];
                blank  = (bcd_out_q[19:16] == '0);
            end
            default: begin
                nibble = 4'd0;
                blank  = 1'b1;
            end
        endcase
    end

    assign seg_bits = blank ? 7'b0000000 : seg_decode(nibble);
    assign {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g} = seg_bits;
    assign digit_en = ~(5'b00001 << digit_idx_q);

endmodule

// File: tb/tb_product_bcd_display.sv
// -----------------------------------------------------------------------------
// tb_product_bcd_display
//
// Directed sequence with randomized products, checked against an arithmetic
// reference: BCD digits from division by powers of ten, scan position from the
// number of clock edges since reset, segment patterns from a digit table.
// -----------------------------------------------------------------------------
module tb_product_bcd_display;

    localparam int RD = 4;

    localparam logic [6:0] SEG_TBL [0:9] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
        7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
    };

    logic       clk = 1'b0;
    logic       reset_a;
    logic [4:0] digit_en;
    logic       seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g;

    product_bcd_display_if bus();

    product_bcd_display #(.REFRESH_DIV(RD)) dut (
        .clk      (clk),
        .reset_a  (reset_a),
        .bus      (bus),
        .digit_en (digit_en),
        .seg_a    (seg_a),
        .seg_b    (seg_b),
        .seg_c    (seg_c),
        .seg_d    (seg_d),
        .seg_e    (seg_e),
        .seg_f    (seg_f),
        .seg_g    (seg_g)
    );

    always #5 clk = ~clk;

    int checks    = 0;
    int errors    = 0;
    int edges     = 0;   // clock edges since reset release
    int shown_val = 0;   // value the display is expected to be showing

    always @(posedge clk or negedge reset_a) begin
        if (!reset_a) edges <= 0;
        else          edges <= edges + 1;
    end

    function automatic int pow10(input int k);
        int p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        for (int i = 0; i < 5; i++) r[i*4 +: 4] = 4'((v / pow10(i)) % 10);
        return r;
    endfunction

    function automatic logic [6:0] exp_seg(input int val, input int idx);
        if (idx > 0 && val < pow10(idx)) return 7'b0000000;
        return SEG_TBL[(val / pow10(idx)) % 10];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_display();
        int         idx;
        logic [4:0] one;
        logic [4:0] en_exp;
        idx    = (edges / RD) % 5;
        one    = 5'b00001;
        en_exp = ~(one << idx);
        check("digit_en", digit_en, en_exp);
        check("segments", {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g},
              exp_seg(shown_val, idx));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); @(negedge clk);
            check("idle_busy", bus.busy, 0);
            check("idle_valid", bus.bcd_valid, 0);
            check("idle_bcd_out", bus.bcd_out, to_bcd(shown_val));
            check_display();
        end
    endtask

    // Expects done_flag=1 and product_in=v already driven ahead of the next
    // rising edge (E0). cyc counts the clock edges after E0.
    task automatic convert_body(input int v, input int hold, input bit retrig);
        logic [19:0] old_bcd;
        logic [19:0] new_bcd;
        int          last;
        old_bcd = to_bcd(shown_val);
        new_bcd = to_bcd(v);
        last    = (hold + 1 > 18) ? hold + 1 : 18;
        for (int cyc = 0; cyc <= last; cyc++) begin
            @(posedge clk); @(negedge clk);
            if (cyc == 17) shown_val = v;
            check("conv_busy", bus.busy, (cyc <= 16) ? 1 : 0);
            check("conv_valid", bus.bcd_valid, (cyc == 17) ? 1 : 0);
            check("conv_bcd_out", bus.bcd_out, (cyc >= 17) ? new_bcd : old_bcd);
            check_display();
            bus.product_in = 16'($urandom);
            if (cyc + 1 >= hold && !(retrig && cyc >= 4 && cyc < 8)) bus.done_flag = 1'b0;
            if (retrig && cyc == 4) bus.done_flag = 1'b1;
        end
        bus.done_flag = 1'b0;
    endtask

    task automatic convert(input int v, input int hold, input bit retrig);
        @(negedge clk);
        bus.product_in = 16'(v);
        bus.done_flag  = 1'b1;
        convert_body(v, hold, retrig);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_valid"}, bus.bcd_valid, 0);
        check({tag, "_bcd_out"}, bus.bcd_out, 0);
        check({tag, "_digit_en"}, digit_en, 5'b11110);
        check({tag, "_segs"}, {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g}, 7'b1111110);
    endtask

    initial begin
        int v;
        reset_a        = 1'b0;
        bus.done_flag  = 1'b0;
        bus.product_in = 16'd0;
        #3;
        check_reset_state("reset");
        repeat (2) @(negedge clk);
        check_reset_state("reset_hold");
        #2 reset_a = 1'b1;
        idle(3);

        // 11 x 85
        convert(935, 1, 0);
        idle(2);

        // all five digits lit, full scan cycle observed
        convert(65535, 1, 0);
        idle(25);

        // zero: only digit 0 lit
        convert(0, 1, 0);
        idle(22);

        for (int t = 0; t < 6; t++) begin
            v = int'($urandom_range(0, 65535));
            convert(v, 1, 0);
            idle(3);
        end
        convert(int'($urandom_range(0, 999)), 1, 0);
        idle(12);

        // done_flag held for 40 clocks while product_in wanders
        convert(int'($urandom_range(0, 65535)), 40, 0);
        idle(3);

        // second edge at E5 ignored
        convert(int'($urandom_range(0, 65535)), 1, 1);
        idle(3);

        // reset in the middle of a conversion
        @(negedge clk);
        bus.product_in = 16'($urandom_range(1, 65535));
        bus.done_flag  = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(posedge clk); @(negedge clk);
            check("abort_busy", bus.busy, 1);
            check("abort_valid", bus.bcd_valid, 0);
            check("abort_bcd_out", bus.bcd_out, to_bcd(shown_val));
            bus.product_in = 16'($urandom);
            bus.done_flag  = 1'b0;
        end
        #2 reset_a = 1'b0;
        #1;
        shown_val = 0;
        check_reset_state("abort_reset");
        repeat (2) @(negedge clk);
        check_reset_state("abort_reset_hold");
        #2 reset_a = 1'b1;
        idle(20);
        convert(int'($urandom_range(0, 65535)), 1, 0);
        idle(2);

        // done_flag already high at reset release
        @(negedge clk);
        #2 reset_a = 1'b0;
        v = int'($urandom_range(0, 65535));
        bus.product_in = 16'(v);
        bus.done_flag  = 1'b1;
        shown_val = 0;
        @(negedge clk);
        check_reset_state("prerelease");
        #2 reset_a = 1'b1;
        convert_body(v, 1, 0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
